// File: rtl/ts_demuxer.sv
`default_nettype none
// ts_demuxer: splits a tagged pseudo-TS stream into 4 TS streams, restoring the 0x47 sync byte.
// Define TS_DEMUX_STATS_EN to add per-channel packet counters and an error counter.
module ts_demuxer #(
  parameter int         PKT_LEN   = 188,
  parameter int         LOCK_PKTS = 3,
  parameter logic [7:0] TAG_BASE  = 8'hB8
) (
  input  logic        CLK,
  input  logic        RST,
`ifdef TS_DEMUX_STATS_EN
  input  logic        CNT_CLR,
  output logic [63:0] PKT_CNT,
  output logic [15:0] ERR_CNT,
`endif
  input  logic [7:0]  DATA_IN,
  input  logic        D_VALID_IN,
  input  logic        P_SYNC_IN,
  output logic [31:0] DATA_OUT,
  output logic [3:0]  D_VALID_OUT,
  output logic [3:0]  P_SYNC_OUT,
  output logic        LOCKED,
  output logic        ERR
);

  typedef enum logic [1:0] {HUNT, PASS, EXPECT, DROP} state_t;

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_PKTS);

  state_t      r_state;
  logic [7:0]  r_byte_cnt;
  logic [3:0]  r_good_cnt;
  logic [1:0]  r_cur_ch;
  logic [31:0] r_data;
  logic [3:0]  r_dv;
  logic [3:0]  r_ps;
  logic        r_locked;
  logic        r_err;

  logic        w_tag_ok;
  logic        w_sync;
  logic        w_last;
  logic        w_in_pkt;
  logic        w_err;
  logic        w_complete;
  logic [3:0]  w_good_nxt;

  always_comb begin
    w_tag_ok   = (DATA_IN[7:2] == TAG_BASE[7:2]);
    w_sync     = D_VALID_IN & P_SYNC_IN;
    w_last     = (r_byte_cnt == LAST_IDX);
    w_in_pkt   = (r_state == PASS) || (r_state == DROP);
    // A sync inside a packet is a short packet; a non-sync byte in EXPECT is lost framing.
    w_err      = (w_sync & (~w_tag_ok | w_in_pkt)) |
                 (D_VALID_IN & ~P_SYNC_IN & (r_state == EXPECT));
    w_complete = D_VALID_IN & ~P_SYNC_IN & (r_state == PASS) & w_last;
    w_good_nxt = r_good_cnt;
    if (w_err)
      w_good_nxt = 4'd0;
    else if (w_complete && (r_good_cnt < LOCK_N))
      w_good_nxt = r_good_cnt + 4'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= HUNT;
      r_byte_cnt <= 8'd0;
      r_good_cnt <= 4'd0;
      r_cur_ch   <= 2'd0;
      r_data     <= 32'd0;
      r_dv       <= 4'd0;
      r_ps       <= 4'd0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_dv       <= 4'd0;
      r_ps       <= 4'd0;
      r_err      <= w_err;
      r_good_cnt <= w_good_nxt;
      r_locked   <= (w_good_nxt == LOCK_N);
      if (w_sync) begin
        // Every sync byte is treated as a tag byte, whatever state we are in.
        r_byte_cnt <= 8'd1;
        if (w_tag_ok) begin
          r_cur_ch                             <= DATA_IN[1:0];
          r_data[{DATA_IN[1:0], 3'b000} +: 8]  <= 8'h47;
          r_dv[DATA_IN[1:0]]                   <= 1'b1;
          r_ps[DATA_IN[1:0]]                   <= 1'b1;
          r_state                              <= PASS;
        end else begin
          r_state <= (r_state == EXPECT) ? HUNT : DROP;
        end
      end else if (D_VALID_IN) begin
        case (r_state)
          HUNT: begin
            r_byte_cnt <= 8'd0;
          end
          PASS: begin
            r_data[{r_cur_ch, 3'b000} +: 8] <= DATA_IN;
            r_dv[r_cur_ch]                  <= 1'b1;
            if (w_last) begin
              r_byte_cnt <= 8'd0;
              r_state    <= EXPECT;
            end else begin
              r_byte_cnt <= r_byte_cnt + 8'd1;
            end
          end
          DROP: begin
            if (w_last) begin
              r_byte_cnt <= 8'd0;
              r_state    <= EXPECT;
            end else begin
              r_byte_cnt <= r_byte_cnt + 8'd1;
            end
          end
          default: begin
            r_byte_cnt <= 8'd0;
            r_state    <= HUNT;
          end
        endcase
      end
    end
  end

  assign DATA_OUT    = r_data;
  assign D_VALID_OUT = r_dv;
  assign P_SYNC_OUT  = r_ps;
  assign LOCKED      = r_locked;
  assign ERR         = r_err;

`ifdef TS_DEMUX_STATS_EN
  logic [63:0] r_pkt_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pkt_cnt <= 64'd0;
      r_err_cnt <= 16'd0;
    end else if (CNT_CLR) begin
      r_pkt_cnt <= 64'd0;
      r_err_cnt <= 16'd0;
    end else begin
      if (w_complete)
        r_pkt_cnt[{r_cur_ch, 4'b0000} +: 16] <= r_pkt_cnt[{r_cur_ch, 4'b0000} +: 16] + 16'd1;
      if (w_err && (r_err_cnt != 16'hFFFF))
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign PKT_CNT = r_pkt_cnt;
  assign ERR_CNT = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ts_demuxer.sv
`default_nettype none
// tb_ts_demuxer: directed self-checking bench for ts_demuxer.
module tb_ts_demuxer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  DATA_IN = 8'h00;
  logic        D_VALID_IN = 1'b0;
  logic        P_SYNC_IN = 1'b0;
  logic [31:0] DATA_OUT;
  logic [3:0]  D_VALID_OUT;
  logic [3:0]  P_SYNC_OUT;
  logic        LOCKED;
  logic        ERR;
`ifdef TS_DEMUX_STATS_EN
  logic        CNT_CLR = 1'b0;
  logic [63:0] PKT_CNT;
  logic [15:0] ERR_CNT;
`endif

  int n_vec = 0;
  int n_err = 0;

  ts_demuxer dut (
    .CLK         (CLK),
    .RST         (RST),
`ifdef TS_DEMUX_STATS_EN
    .CNT_CLR     (CNT_CLR),
    .PKT_CNT     (PKT_CNT),
    .ERR_CNT     (ERR_CNT),
`endif
    .DATA_IN     (DATA_IN),
    .D_VALID_IN  (D_VALID_IN),
    .P_SYNC_IN   (P_SYNC_IN),
    .DATA_OUT    (DATA_OUT),
    .D_VALID_OUT (D_VALID_OUT),
    .P_SYNC_OUT  (P_SYNC_OUT),
    .LOCKED      (LOCKED),
    .ERR         (ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] pay(input int p, input int i);
    return 8'(p * 31 + i * 3 + 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One input cycle; ch < 0 means no output strobe is expected for it.
  task automatic step(input logic [7:0] d, input logic v, input logic s, input int ch,
                      input logic [7:0] ed, input logic eps, input logic eerr, input string tag);
    logic [3:0] exp_dv;
    logic [7:0] obs_lane;
    @(negedge CLK);
    DATA_IN    = d;
    D_VALID_IN = v;
    P_SYNC_IN  = s;
    @(posedge CLK);
    #1;
    exp_dv   = (ch >= 0) ? 4'(1 << ch) : 4'd0;
    obs_lane = (ch >= 0) ? DATA_OUT[8*ch +: 8] : 8'h00;
    chk(tag, {36'd0, D_VALID_OUT, P_SYNC_OUT, 3'd0, ERR, obs_lane},
             {36'd0, exp_dv, (eps ? exp_dv : 4'd0), 3'd0, eerr, ((ch >= 0) ? ed : 8'h00)});
    D_VALID_IN = 1'b0;
    P_SYNC_IN  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] tag, input int p, input int ch, input int first,
                          input int last, input bit gap, input logic err0);
    for (int i = first; i <= last; i++) begin
      if (gap && ($urandom_range(0, 1) == 1))
        step(8'hEE, 1'b0, 1'b0, -1, 8'h00, 1'b0, 1'b0, "gap");
      if (i == 0)
        step(tag, 1'b1, 1'b1, ch, 8'h47, 1'b1, err0, "tag_byte");
      else
        step(pay(p, i), 1'b1, 1'b0, ch, pay(p, i), 1'b0, 1'b0, "data_byte");
    end
  endtask

  initial begin
    #2;
    chk("reset_outputs", {22'd0, DATA_OUT, D_VALID_OUT, P_SYNC_OUT, LOCKED, ERR}, 64'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Back-to-back packets on all four channels; lock after the third.
    send_pkt(8'hB8, 0, 0, 0, 187, 1'b0, 1'b0);
    chk("locked_after_1", {63'd0, LOCKED}, 64'd0);
    send_pkt(8'hB9, 1, 1, 0, 187, 1'b0, 1'b0);
    chk("locked_after_2", {63'd0, LOCKED}, 64'd0);
    send_pkt(8'hBA, 2, 2, 0, 187, 1'b0, 1'b0);
    chk("locked_after_3", {63'd0, LOCKED}, 64'd1);
    send_pkt(8'hBB, 3, 3, 0, 187, 1'b0, 1'b0);
    chk("locked_after_4", {63'd0, LOCKED}, 64'd1);

    // Same stream with random valid gaps.
    send_pkt(8'hB8, 0, 0, 0, 187, 1'b1, 1'b0);
    send_pkt(8'hB9, 1, 1, 0, 187, 1'b1, 1'b0);
    send_pkt(8'hBA, 2, 2, 0, 187, 1'b1, 1'b0);
    send_pkt(8'hBB, 3, 3, 0, 187, 1'b1, 1'b0);
    chk("locked_after_gaps", {63'd0, LOCKED}, 64'd1);

    // Bad tag: error, whole packet discarded, next good packet forwarded.
    send_pkt(8'h5A, 5, -1, 0, 187, 1'b0, 1'b1);
    chk("locked_after_bad_tag", {63'd0, LOCKED}, 64'd0);
    send_pkt(8'hB9, 6, 1, 0, 187, 1'b0, 1'b0);
    send_pkt(8'hBA, 7, 2, 0, 187, 1'b0, 1'b0);
    send_pkt(8'hBB, 8, 3, 0, 187, 1'b0, 1'b0);
    chk("relock", {63'd0, LOCKED}, 64'd1);

    // Short ch2 packet: sync at byte 100 starts ch3 immediately.
    send_pkt(8'hBA, 9, 2, 0, 99, 1'b0, 1'b0);
    send_pkt(8'hBB, 10, 3, 0, 0, 1'b0, 1'b1);
    chk("locked_after_short", {63'd0, LOCKED}, 64'd0);
    send_pkt(8'hBB, 10, 3, 1, 187, 1'b0, 1'b0);

    // Reset mid-packet, released while mid-packet bytes keep arriving.
    send_pkt(8'hBB, 11, 3, 0, 49, 1'b0, 1'b0);
    @(negedge CLK);
    DATA_IN    = pay(11, 50);
    D_VALID_IN = 1'b1;
    RST        = 1'b0;
    #1;
    chk("async_reset", {22'd0, DATA_OUT, D_VALID_OUT, P_SYNC_OUT, LOCKED, ERR}, 64'd0);
    D_VALID_IN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    send_pkt(8'hBB, 11, -1, 60, 120, 1'b0, 1'b0);
    chk("data_after_reset", {32'd0, DATA_OUT}, 64'd0);
    send_pkt(8'hB8, 12, 0, 0, 187, 1'b0, 1'b0);

`ifdef TS_DEMUX_STATS_EN
    @(negedge CLK);
    CNT_CLR = 1'b1;
    @(posedge CLK);
    #1;
    CNT_CLR = 1'b0;
    chk("clr_pkt_cnt", PKT_CNT, 64'd0);
    chk("clr_err_cnt", {48'd0, ERR_CNT}, 64'd0);
    for (int k = 0; k < 5; k++)
      send_pkt(8'hB8, 20 + k, 0, 0, 187, 1'b0, 1'b0);
    send_pkt(8'h5A, 30, -1, 0, 187, 1'b0, 1'b1);
    send_pkt(8'h33, 31, -1, 0, 187, 1'b0, 1'b1);
    chk("pkt_cnt_5", PKT_CNT, 64'd5);
    chk("err_cnt_2", {48'd0, ERR_CNT}, 64'd2);
    @(negedge CLK);
    CNT_CLR = 1'b1;
    @(posedge CLK);
    #1;
    CNT_CLR = 1'b0;
    chk("clr2_pkt_cnt", PKT_CNT, 64'd0);
    chk("clr2_err_cnt", {48'd0, ERR_CNT}, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
